digit_renderer: RTL and testbench

DIGIT_RENDERER -- requirements
Module: digit_renderer

---
 rtl/digit_renderer.sv | 190 +++++++++++++++++++
 tb/tb_digit_renderer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_renderer.sv
// digit_renderer
// Converts a 10-bit height (cm) to three BCD digits and overlays them as a
// 24x16 text box on a streaming pixel pipeline.
//
// Ports
//   clk, reset           : single clock, synchronous active-high reset
//   value_valid/value    : height offer (unsigned, saturated to 999)
//   value_ready          : high only while the converter is idle
//   frame_start          : one-cycle pulse; latches the newest converted value
//   px_valid/px_x/px_y   : incoming pixel coordinate stream
//   glyph_sel/col/row    : address to the external glyph ROM (from stage 1)
//   glyph_data           : combinational ROM pixel for the current address
//   pix_valid/pix_out    : rendered pixel, two cycles after px_valid
//                          (6'b111111 is white background)
module digit_renderer #(
  parameter logic [9:0] X0 = 10'd0,
  parameter logic [9:0] Y0 = 10'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       value_valid,
  input  logic [9:0] value,
  output logic       value_ready,
  input  logic       frame_start,
  input  logic       px_valid,
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  output logic [3:0] glyph_sel,
  output logic [4:0] glyph_col,
  output logic [4:0] glyph_row,
  input  logic [5:0] glyph_data,
  output logic       pix_valid,
  output logic [5:0] pix_out
);

  localparam logic [5:0] WHITE = 6'b111111;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  bin_reg, bin_next;
  logic [11:0] bcd_reg, bcd_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [11:0] pend_bcd_reg, pend_bcd_next;
  logic        pend_new_reg, pend_new_next;
  logic [11:0] disp_bcd_reg, disp_bcd_next;
  logic [11:0] bcd_adj;

  // Shift-add-3 correction: any digit >= 5 gets +3 before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    bin_next      = bin_reg;
    bcd_next      = bcd_reg;
    cnt_next      = cnt_reg;
    pend_bcd_next = pend_bcd_reg;
    pend_new_next = pend_new_reg;
    disp_bcd_next = disp_bcd_reg;
    value_ready   = 1'b0;

    // Frame hand-off looks at the registered pend state, so a completion in
    // the same cycle is only picked up by the following frame_start.
    if (frame_start && pend_new_reg) begin
      disp_bcd_next = pend_bcd_reg;
      pend_new_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        value_ready = 1'b1;
        if (value_valid) begin
          bin_next   = (value > 10'd999) ? 10'd999 : value;
          bcd_next   = 12'd0;
          cnt_next   = 4'd0;
          state_next = CONV;
        end
      end
      CONV: begin
        bcd_next = {bcd_adj[10:0], bin_reg[9]};
        bin_next = {bin_reg[8:0], 1'b0};
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd9) state_next = DONE;
      end
      DONE: begin
        pend_bcd_next = bcd_reg;
        pend_new_next = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- pixel pipeline ----------------
  logic [10:0] x_ext, y_ext;
  logic [4:0]  dx;
  logic [3:0]  dy;
  logic        in_box;

  assign x_ext = {1'b0, px_x};
  assign y_ext = {1'b0, px_y};
  // Only the low bits of the offset matter once the pixel is inside the box.
  assign dx = px_x[4:0] - X0[4:0];
  assign dy = px_y[3:0] - Y0[3:0];
  assign in_box = px_valid &&
                  (x_ext >= {1'b0, X0}) && (x_ext < {1'b0, X0} + 11'd24) &&
                  (y_ext >= {1'b0, Y0}) && (y_ext < {1'b0, Y0} + 11'd16);

  logic       s1_valid_reg, s1_inbox_reg;
  logic [1:0] s1_d_reg;
  logic [2:0] s1_col_reg;
  logic [3:0] s1_row_reg;
  logic       pix_valid_reg;
  logic [5:0] pix_out_reg;

  // digit[0] = hundreds, digit[2] = units
  logic [3:0] digit [3];
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      assign digit[gi] = disp_bcd_reg[11 - 4*gi -: 4];
    end
  endgenerate

  logic [3:0] sel_digit;
  logic       blank;

  always_comb begin
    sel_digit = 4'd0;
    blank     = 1'b0;
    case (s1_d_reg)
      2'd0: begin
        sel_digit = digit[0];
        blank     = (digit[0] == 4'd0);
      end
      2'd1: begin
        sel_digit = digit[1];
        blank     = (digit[0] == 4'd0) && (digit[1] == 4'd0);
      end
      default: sel_digit = digit[2];
    endcase
  end

  assign glyph_sel = s1_inbox_reg ? sel_digit : 4'd0;
  assign glyph_col = {2'b00, s1_col_reg};
  assign glyph_row = {1'b0, s1_row_reg};
  assign pix_valid = pix_valid_reg;
  assign pix_out   = pix_out_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bin_reg       <= 10'd0;
      bcd_reg       <= 12'd0;
      cnt_reg       <= 4'd0;
      pend_bcd_reg  <= 12'd0;
      pend_new_reg  <= 1'b0;
      disp_bcd_reg  <= 12'd0;
      s1_valid_reg  <= 1'b0;
      s1_inbox_reg  <= 1'b0;
      s1_d_reg      <= 2'd0;
      s1_col_reg    <= 3'd0;
      s1_row_reg    <= 4'd0;
      pix_valid_reg <= 1'b0;
      pix_out_reg   <= WHITE;
    end else begin
      state_reg     <= state_next;
      bin_reg       <= bin_next;
      bcd_reg       <= bcd_next;
      cnt_reg       <= cnt_next;
      pend_bcd_reg  <= pend_bcd_next;
      pend_new_reg  <= pend_new_next;
      disp_bcd_reg  <= disp_bcd_next;
      s1_valid_reg  <= px_valid;
      s1_inbox_reg  <= in_box;
      s1_d_reg      <= in_box ? dx[4:3] : 2'd0;
      s1_col_reg    <= in_box ? dx[2:0] : 3'd0;
      s1_row_reg    <= in_box ? dy : 4'd0;
      pix_valid_reg <= s1_valid_reg;
      // in-box implies valid, so bubbles and outside pixels come out white
      pix_out_reg   <= (s1_inbox_reg && !blank) ? glyph_data : WHITE;
    end
  end

endmodule

// File: tb/tb_digit_renderer.sv
// tb_digit_renderer
// Self-checking bench for digit_renderer: drives height values and pixel
// streams, models the glyph ROM, and compares against a decimal reference.
module tb_digit_renderer;

  localparam int BX = 0;
  localparam int BY = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       value_valid = 1'b0;
  logic [9:0] value = '0;
  logic       value_ready;
  logic       frame_start = 1'b0;
  logic       px_valid = 1'b0;
  logic [9:0] px_x = '0;
  logic [9:0] px_y = '0;
  logic [3:0] glyph_sel;
  logic [4:0] glyph_col;
  logic [4:0] glyph_row;
  logic [5:0] glyph_data;
  logic       pix_valid;
  logic [5:0] pix_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_renderer #(.X0(10'(BX)), .Y0(10'(BY))) dut (
    .clk(clk), .reset(reset),
    .value_valid(value_valid), .value(value), .value_ready(value_ready),
    .frame_start(frame_start),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .glyph_sel(glyph_sel), .glyph_col(glyph_col), .glyph_row(glyph_row),
    .glyph_data(glyph_data),
    .pix_valid(pix_valid), .pix_out(pix_out)
  );

  // Glyph ROM stand-in: never returns 63, so glyph pixels differ from white.
  function automatic logic [5:0] rom(input int s, input int c, input int r);
    return 6'((s * 13 + c * 5 + r * 3 + 1) % 63);
  endfunction

  always_comb glyph_data = rom(int'(glyph_sel), int'(glyph_col), int'(glyph_row));

  // Decimal reference
  function automatic int digit_at(input int n, input int d);
    if (d == 0) return n / 100;
    if (d == 1) return (n / 10) % 10;
    return n % 10;
  endfunction

  function automatic int is_blank(input int n, input int d);
    if (d == 0) return (n < 100) ? 1 : 0;
    if (d == 1) return (n < 10) ? 1 : 0;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  // pending stimulus and recorded results
  int px_q[$], py_q[$], pv_q[$];
  int rx[$], ry[$], rv[$];
  int e_pv[$], e_po[$], e_sel[$], e_col[$], e_row[$], e_inb[$];
  int o_pv[$], o_po[$], o_sel[$], o_col[$], o_row[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic accept(input int v);
    value = 10'(v);
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    $display("accept value=%0d", v);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // accept, wait until the converter is idle again, then hand off
  task automatic settle(input int v);
    accept(v);
    wait_cycles(11);
    frame_pulse();
  endtask

  task automatic add_px(input int x, input int y, input int v);
    px_q.push_back(x);
    py_q.push_back(y);
    pv_q.push_back(v);
  endtask

  task automatic clear_records();
    rx.delete(); ry.delete(); rv.delete();
    e_pv.delete(); e_po.delete(); e_sel.delete(); e_col.delete(); e_row.delete(); e_inb.delete();
    o_pv.delete(); o_po.delete(); o_sel.delete(); o_col.delete(); o_row.delete();
  endtask

  // Drives queued pixels back to back, records outputs and model expectations.
  task automatic run_stream(input int disp);
    int n;
    n = px_q.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        px_valid = (pv_q[i] != 0);
        px_x = 10'(px_q[i]);
        px_y = 10'(py_q[i]);
      end else begin
        px_valid = 1'b0;
        px_x = '0;
        px_y = '0;
      end
      step();
      if (i < n) begin
        o_sel.push_back(int'(glyph_sel));
        o_col.push_back(int'(glyph_col));
        o_row.push_back(int'(glyph_row));
      end
      if (i >= 1) begin
        o_pv.push_back(int'(pix_valid));
        o_po.push_back(int'(pix_out));
      end
    end
    for (int i = 0; i < n; i++) begin
      int x, y, inb, d, c, r, dig;
      x = px_q[i]; y = py_q[i];
      inb = (pv_q[i] != 0 && x >= BX && x < BX + 24 && y >= BY && y < BY + 16) ? 1 : 0;
      d = (x - BX) / 8; c = (x - BX) % 8; r = y - BY;
      dig = inb ? digit_at(disp, d) : 0;
      rx.push_back(x); ry.push_back(y); rv.push_back(pv_q[i]);
      e_inb.push_back(inb);
      e_pv.push_back(pv_q[i] != 0 ? 1 : 0);
      e_po.push_back((inb != 0 && is_blank(disp, d) == 0) ? int'(rom(dig, c, r)) : 63);
      e_sel.push_back(dig);
      e_col.push_back(c);
      e_row.push_back(r);
    end
    $display("scan disp=%0d pixels=%0d", disp, n);
    px_q.delete(); py_q.delete(); pv_q.delete();
  endtask

  task automatic test_reset();
    value_valid = 1'b1;
    value = 10'd500;
    frame_start = 1'b1;
    do_reset();
    value_valid = 1'b0;
    frame_start = 1'b0;
    checks++;
    if (value_ready !== 1'b1 || pix_valid !== 1'b0 || pix_out !== 6'h3F) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b pix_valid=%b pix_out=%h, want 1 0 3f",
               value_ready, pix_valid, pix_out);
    end
    checks++;
    if (glyph_sel !== 4'd0 || glyph_col !== 5'd0 || glyph_row !== 5'd0) begin
      errors++;
      $display("FAIL reset_glyph_addr: got sel=%0d col=%0d row=%0d, want 0 0 0",
               glyph_sel, glyph_col, glyph_row);
    end
    clear_records();
    for (int y = 0; y < 16; y += 5)
      for (int x = 0; x < 28; x++) add_px(x, y, 1);
    run_stream(0);
    for (int i = 0; i < rx.size(); i++) begin
      checks++;
      if (o_pv[i] !== e_pv[i] || o_po[i] !== e_po[i]) begin
        errors++;
        $display("FAIL reset_scan_pix (%0d,%0d): got valid=%0d pix=%02h, want valid=%0d pix=%02h",
                 rx[i], ry[i], o_pv[i], o_po[i], e_pv[i], e_po[i]);
      end
      if (e_inb[i] != 0) begin
        checks++;
        if (o_sel[i] !== e_sel[i] || o_col[i] !== e_col[i] || o_row[i] !== e_row[i]) begin
          errors++;
          $display("FAIL reset_scan_addr (%0d,%0d): got %0d/%0d/%0d, want %0d/%0d/%0d",
                   rx[i], ry[i], o_sel[i], o_col[i], o_row[i], e_sel[i], e_col[i], e_row[i]);
        end
      end
    end
  endtask

  task automatic test_convert_timing();
    accept(175);
    for (int k = 1; k <= 11; k++) begin
      checks++;
      if (value_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_busy cycle +%0d: got %b, want 0", k, value_ready);
      end
      step();
    end
    checks++;
    if (value_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle cycle +12: got %b, want 1", value_ready);
    end
    frame_pulse();
    clear_records();
    for (int x = 0; x < 24; x++) add_px(x, 5, 1);
    run_stream(175);
    for (int i = 0; i < rx.size(); i++) begin
      checks++;
      if (o_pv[i] !== e_pv[i] || o_po[i] !== e_po[i] || o_sel[i] !== e_sel[i]) begin
        errors++;
        $display("FAIL convert_175 (%0d,%0d): got v=%0d pix=%02h sel=%0d, want v=%0d pix=%02h sel=%0d",
                 rx[i], ry[i], o_pv[i], o_po[i], o_sel[i], e_pv[i], e_po[i], e_sel[i]);
      end
    end
  endtask

  task automatic test_saturation_blanking();
    int vals[7] = '{1023, 1000, 999, 7, 10, 100, 0};
    clear_records();
    foreach (vals[j]) begin
      settle(vals[j]);
      for (int x = 0; x < 24; x++) begin
        add_px(x, 4, 1);
        add_px(x, 11, 1);
      end
      run_stream(sat(vals[j]));
    end
    for (int i = 0; i < rx.size(); i++) begin
      checks++;
      if (o_pv[i] !== e_pv[i] || o_po[i] !== e_po[i] || o_sel[i] !== e_sel[i]) begin
        errors++;
        $display("FAIL sat_blank rec %0d (%0d,%0d): got v=%0d pix=%02h sel=%0d, want v=%0d pix=%02h sel=%0d",
                 i, rx[i], ry[i], o_pv[i], o_po[i], o_sel[i], e_pv[i], e_po[i], e_sel[i]);
      end
    end
  endtask

  task automatic test_pixel_boundaries();
    settle(175);
    clear_records();
    add_px(25, 3, 1);
    add_px(8, 3, 1);
    add_px(8, 3, 0);
    add_px(23, 15, 1);
    add_px(24, 0, 1);
    add_px(0, 16, 1);
    run_stream(175);
    checks++;
    if (o_pv[0] !== 1 || o_po[0] !== 63) begin
      errors++;
      $display("FAIL outside_x25: got v=%0d pix=%02h, want v=1 pix=3f", o_pv[0], o_po[0]);
    end
    checks++;
    if (o_sel[1] !== 7 || o_col[1] !== 0 || o_row[1] !== 3) begin
      errors++;
      $display("FAIL tens_addr_x8: got %0d/%0d/%0d, want 7/0/3", o_sel[1], o_col[1], o_row[1]);
    end
    checks++;
    if (o_pv[1] !== 1 || o_po[1] !== int'(rom(7, 0, 3))) begin
      errors++;
      $display("FAIL tens_pix_x8: got v=%0d pix=%02h, want v=1 pix=%02h", o_pv[1], o_po[1], rom(7, 0, 3));
    end
    checks++;
    if (o_pv[2] !== 0 || o_po[2] !== 63) begin
      errors++;
      $display("FAIL bubble: got v=%0d pix=%02h, want v=0 pix=3f", o_pv[2], o_po[2]);
    end
    checks++;
    if (o_po[3] !== int'(rom(5, 7, 15)) || o_sel[3] !== 5) begin
      errors++;
      $display("FAIL corner_23_15: got pix=%02h sel=%0d, want pix=%02h sel=5", o_po[3], o_sel[3], rom(5, 7, 15));
    end
    checks++;
    if (o_po[4] !== 63 || o_po[5] !== 63 || o_pv[4] !== 1 || o_pv[5] !== 1) begin
      errors++;
      $display("FAIL edge_24_16: got pix=%02h,%02h v=%0d,%0d, want 3f,3f 1,1", o_po[4], o_po[5], o_pv[4], o_pv[5]);
    end
  endtask

  task automatic test_frame_sync();
    clear_records();
    // completion and frame_start in the same cycle: old value stays up
    accept(42);
    wait_cycles(10);
    frame_pulse();
    for (int x = 0; x < 24; x++) add_px(x, 9, 1);
    run_stream(175);
    frame_pulse();
    for (int x = 0; x < 24; x++) add_px(x, 9, 1);
    run_stream(42);
    // two completions before a frame: latest wins
    accept(311);
    wait_cycles(11);
    accept(864);
    wait_cycles(11);
    frame_pulse();
    for (int x = 0; x < 24; x++) add_px(x, 2, 1);
    run_stream(864);
    // offers while busy are dropped
    accept(500);
    value_valid = 1'b1;
    value = 10'd123;
    wait_cycles(10);
    value_valid = 1'b0;
    wait_cycles(1);
    frame_pulse();
    for (int x = 0; x < 24; x++) add_px(x, 13, 1);
    run_stream(500);
    for (int i = 0; i < rx.size(); i++) begin
      checks++;
      if (o_pv[i] !== e_pv[i] || o_po[i] !== e_po[i] || o_sel[i] !== e_sel[i]) begin
        errors++;
        $display("FAIL frame_sync rec %0d (%0d,%0d): got v=%0d pix=%02h sel=%0d, want v=%0d pix=%02h sel=%0d",
                 i, rx[i], ry[i], o_pv[i], o_po[i], o_sel[i], e_pv[i], e_po[i], e_sel[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    accept(555);
    wait_cycles(5);
    reset = 1'b1;
    frame_start = 1'b1;
    value_valid = 1'b1;
    value = 10'd3;
    step();
    reset = 1'b0;
    frame_start = 1'b0;
    value_valid = 1'b0;
    checks++;
    if (value_ready !== 1'b1 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: got ready=%b pix_valid=%b, want 1 0", value_ready, pix_valid);
    end
    wait_cycles(15);
    checks++;
    if (value_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got ready=%b, want 1", value_ready);
    end
    frame_pulse();
    clear_records();
    for (int x = 0; x < 24; x++) add_px(x, 6, 1);
    run_stream(0);
    for (int i = 0; i < rx.size(); i++) begin
      checks++;
      if (o_pv[i] !== e_pv[i] || o_po[i] !== e_po[i] || o_sel[i] !== e_sel[i]) begin
        errors++;
        $display("FAIL abort_scan (%0d,%0d): got v=%0d pix=%02h sel=%0d, want v=%0d pix=%02h sel=%0d",
                 rx[i], ry[i], o_pv[i], o_po[i], o_sel[i], e_pv[i], e_po[i], e_sel[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_records();
    for (int j = 0; j < 6; j++) begin
      int v;
      v = int'($urandom_range(0, 1023));
      settle(v);
      for (int k = 0; k < 40; k++)
        add_px(int'($urandom_range(0, 31)), int'($urandom_range(0, 19)),
               ($urandom_range(0, 4) != 0) ? 1 : 0);
      run_stream(sat(v));
    end
    for (int i = 0; i < rx.size(); i++) begin
      checks++;
      if (o_pv[i] !== e_pv[i] || o_po[i] !== e_po[i]) begin
        errors++;
        $display("FAIL random_pix rec %0d (%0d,%0d,v%0d): got v=%0d pix=%02h, want v=%0d pix=%02h",
                 i, rx[i], ry[i], rv[i], o_pv[i], o_po[i], e_pv[i], e_po[i]);
      end
      if (e_inb[i] != 0) begin
        checks++;
        if (o_sel[i] !== e_sel[i] || o_col[i] !== e_col[i] || o_row[i] !== e_row[i]) begin
          errors++;
          $display("FAIL random_addr rec %0d (%0d,%0d): got %0d/%0d/%0d, want %0d/%0d/%0d",
                   i, rx[i], ry[i], o_sel[i], o_col[i], o_row[i], e_sel[i], e_col[i], e_row[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert_timing();
    test_saturation_blanking();
    test_pixel_boundaries();
    test_frame_sync();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
